// File: rtl/stroke_sequencer_if.sv
// Point stream from the stroke sequencer to the motion stage.
// master drives the point; slave consumes it through pt_ready.
interface stroke_sequencer_if #(
  parameter int unsigned IW = 7,
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10,
  parameter int unsigned ZW = 9
);
  logic          pt_valid;
  logic          pt_ready;
  logic [XW-1:0] pt_x;
  logic [YW-1:0] pt_y;
  logic [ZW-1:0] pt_z;
  logic          pt_last;
  logic [IW-1:0] pt_stroke;

  modport master (
    output pt_valid, pt_x, pt_y, pt_z, pt_last, pt_stroke,
    input  pt_ready
  );

  modport slave (
    input  pt_valid, pt_x, pt_y, pt_z, pt_last, pt_stroke,
    output pt_ready
  );
endinterface

// File: rtl/stroke_sequencer.sv
// Walks a run of strokes in the stroke-point ROM bank and streams every
// x/y/z point of each stroke to the motion stage over a valid/ready link.
module stroke_sequencer #(
  parameter int unsigned IW = 7,
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10,
  parameter int unsigned ZW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IW-1:0]        first_stroke,
  input  logic [IW-1:0]        stroke_cnt,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        mem_m,
  output logic [IW-1:0]        mem_n,
  input  logic [XW-1:0]        mem_x,
  input  logic [YW-1:0]        mem_y,
  input  logic [ZW-1:0]        mem_z,
  input  logic [IW-1:0]        mem_len,
  stroke_sequencer_if.master   pt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEN   = 2'd1,
    S_FETCH = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] m_q, m_d;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] left_q, left_d;
  logic [IW-1:0] len_q, len_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pt_valid_q, pt_valid_d;
  logic [XW-1:0] pt_x_q, pt_x_d;
  logic [YW-1:0] pt_y_q, pt_y_d;
  logic [ZW-1:0] pt_z_q, pt_z_d;
  logic          pt_last_q, pt_last_d;
  logic [IW-1:0] pt_stroke_q, pt_stroke_d;
  logic          end_stroke;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      left_q      <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pt_valid_q  <= 1'b0;
      pt_x_q      <= '0;
      pt_y_q      <= '0;
      pt_z_q      <= '0;
      pt_last_q   <= 1'b0;
      pt_stroke_q <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      left_q      <= left_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pt_valid_q  <= pt_valid_d;
      pt_x_q      <= pt_x_d;
      pt_y_q      <= pt_y_d;
      pt_z_q      <= pt_z_d;
      pt_last_q   <= pt_last_d;
      pt_stroke_q <= pt_stroke_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    left_d      = left_q;
    len_d       = len_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pt_valid_d  = pt_valid_q;
    pt_x_d      = pt_x_q;
    pt_y_d      = pt_y_q;
    pt_z_d      = pt_z_q;
    pt_last_d   = pt_last_q;
    pt_stroke_d = pt_stroke_q;
    end_stroke  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (stroke_cnt != '0) begin
            m_d     = first_stroke;
            left_d  = stroke_cnt;
            n_d     = '0;
            busy_d  = 1'b1;
            state_d = S_LEN;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_LEN: begin
        len_d = mem_len;
        if (mem_len == '0) begin
          end_stroke = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pt_x_d      = mem_x;
        pt_y_d      = mem_y;
        pt_z_d      = mem_z;
        pt_stroke_d = m_q;
        pt_last_d   = (n_q == len_q - IW'(1));
        pt_valid_d  = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (pt_valid_q && pt.pt_ready) begin
          pt_valid_d = 1'b0;
          if (pt_last_q) begin
            end_stroke = 1'b1;
          end else begin
            n_d     = n_q + IW'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Advance to the next stroke, or finish the run on the last one
    if (end_stroke) begin
      if (left_q == IW'(1)) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        m_d     = m_q + IW'(1);
        left_d  = left_q - IW'(1);
        n_d     = '0;
        state_d = S_LEN;
      end
    end

    // Cancel overrides everything, including a same-edge handshake
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      pt_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_m        = m_q;
  assign mem_n        = n_q;
  assign pt.pt_valid  = pt_valid_q;
  assign pt.pt_x      = pt_x_q;
  assign pt.pt_y      = pt_y_q;
  assign pt.pt_z      = pt_z_q;
  assign pt.pt_last   = pt_last_q;
  assign pt.pt_stroke = pt_stroke_q;

endmodule

// File: tb/tb_stroke_sequencer.sv
// Scoreboard bench for stroke_sequencer: a behavioural ROM, directed runs,
// and a negedge monitor that checks every accepted point and hold stability.
module tb_stroke_sequencer;

  localparam int unsigned IW = 7;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned ZW = 9;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
    logic          last;
    logic [IW-1:0] stroke;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] first_stroke;
  logic [IW-1:0] stroke_cnt;
  logic          abort;
  logic          busy;
  logic          done;
  logic [IW-1:0] mem_m;
  logic [IW-1:0] mem_n;
  logic [XW-1:0] mem_x;
  logic [YW-1:0] mem_y;
  logic [ZW-1:0] mem_z;
  logic [IW-1:0] mem_len;

  stroke_sequencer_if #(.IW(IW), .XW(XW), .YW(YW), .ZW(ZW)) pt_if ();

  stroke_sequencer #(.IW(IW), .XW(XW), .YW(YW), .ZW(ZW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .first_stroke (first_stroke),
    .stroke_cnt   (stroke_cnt),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .mem_m        (mem_m),
    .mem_n        (mem_n),
    .mem_x        (mem_x),
    .mem_y        (mem_y),
    .mem_z        (mem_z),
    .mem_len      (mem_len),
    .pt           (pt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM bank
  function automatic logic [IW-1:0] rom_len(input logic [IW-1:0] m);
    case (m)
      7'd3:    return 7'd2;
      7'd126:  return 7'd1;
      7'd127:  return 7'd0;
      7'd0:    return 7'd2;
      7'd10:   return 7'd4;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [XW-1:0] rom_x(input logic [IW-1:0] m, input logic [IW-1:0] n);
    if (m == 7'd3) return XW'(32'd100 + 32'(n));
    return XW'(32'(m) * 7 + 32'(n));
  endfunction

  function automatic logic [YW-1:0] rom_y(input logic [IW-1:0] m, input logic [IW-1:0] n);
    if (m == 7'd3) return YW'(32'd200 + 32'(n));
    return YW'(32'(m) * 3 + 32'(n) + 400);
  endfunction

  function automatic logic [ZW-1:0] rom_z(input logic [IW-1:0] m, input logic [IW-1:0] n);
    if (m == 7'd3) return ZW'(32'd50 + 32'(n));
    return ZW'(32'(m) + 32'(n) + 1);
  endfunction

  assign mem_x   = rom_x(mem_m, mem_n);
  assign mem_y   = rom_y(mem_m, mem_n);
  assign mem_z   = rom_z(mem_m, mem_n);
  assign mem_len = rom_len(mem_m);

  int    checks;
  int    errors;
  int    beats;
  int    done_cnt;
  beat_t exp_q[$];
  beat_t cur_beat;
  beat_t held;
  logic  hold_pend;

  assign cur_beat = {pt_if.pt_x, pt_if.pt_y, pt_if.pt_z, pt_if.pt_last, pt_if.pt_stroke};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Expected beats of a run, pushed when the run is issued
  task automatic push_run(input logic [IW-1:0] first, input int cnt, input int max_pts);
    int pushed = 0;
    for (int s = 0; s < cnt; s++) begin
      logic [IW-1:0] m;
      logic [IW-1:0] len;
      m   = IW'(32'(first) + s);
      len = rom_len(m);
      for (int n = 0; n < int'(len); n++) begin
        if (pushed < max_pts) begin
          exp_q.push_back({rom_x(m, IW'(n)), rom_y(m, IW'(n)), rom_z(m, IW'(n)),
                           (n == int'(len) - 1), m});
          pushed++;
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks held points
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(pt_if.pt_valid), 64'd1);
        check("hold_beat", 64'(cur_beat), 64'(held));
      end
      if (pt_if.pt_valid && pt_if.pt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual stroke=%0d x=%0d required no beat",
                   pt_if.pt_stroke, pt_if.pt_x);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", 64'(cur_beat), 64'(e));
          beats++;
        end
      end
      hold_pend = pt_if.pt_valid && !pt_if.pt_ready && !abort;
      held      = cur_beat;
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input logic [IW-1:0] first, input logic [IW-1:0] cnt);
    @(posedge clk); #1;
    start        = 1'b1;
    first_stroke = first;
    stroke_cnt   = cnt;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (pt_if.pt_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout actual=no pt_valid required=pt_valid within %0d cycles", nm, max);
  endtask

  task automatic wait_done(input string nm, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout actual=no done required=done within %0d cycles", nm, max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    checks = 0; errors = 0; beats = 0; done_cnt = 0; hold_pend = 1'b0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_stroke = '0; stroke_cnt = '0; pt_if.pt_ready = 1'b0;

    // Reset state
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(pt_if.pt_valid), 64'd0);
    check("rst_beat", 64'(cur_beat), 64'd0);
    check("rst_mem_mn", 64'({mem_m, mem_n}), 64'd0);
    #9 rst_n = 1'b1;

    // 1: basic run, start while busy ignored, exact done timing
    pt_if.pt_ready = 1'b1;
    b0 = beats; d0 = done_cnt;
    push_run(7'd3, 1, 99);
    do_start(7'd3, 7'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      case (k)
        1: check("s1_busy", 64'(busy), 64'd1);
        2: begin
          check("s1_mem_n0", 64'(mem_n), 64'd0);
          start = 1'b1; first_stroke = 7'd10; stroke_cnt = 7'd1;
        end
        3: begin
          start = 1'b0; first_stroke = 7'd3;
          check("s1_latency", 64'(pt_if.pt_valid), 64'd1);
        end
        4: begin
          check("s1_mem_n1", 64'(mem_n), 64'd1);
          check("s1_mem_m", 64'(mem_m), 64'd3);
        end
        6: check("s1_done", 64'(done), 64'd1);
        7: begin
          check("s1_done_pulse", 64'(done), 64'd0);
          check("s1_busy_end", 64'(busy), 64'd0);
        end
        default: ;
      endcase
    end
    repeat (3) @(negedge clk);
    check("s1_beats", 64'(beats - b0), 64'd2);
    check("s1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("s1_queue", 64'(exp_q.size()), 64'd0);

    // 2: backpressure on the first point
    pt_if.pt_ready = 1'b0;
    b0 = beats;
    push_run(7'd3, 1, 99);
    do_start(7'd3, 7'd1);
    wait_valid("s2", 10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("s2_hold_x", 64'(pt_if.pt_x), 64'd100);
    end
    @(posedge clk); #1;
    pt_if.pt_ready = 1'b1;
    wait_done("s2", 20);
    repeat (3) @(negedge clk);
    check("s2_beats", 64'(beats - b0), 64'd2);
    check("s2_queue", 64'(exp_q.size()), 64'd0);

    // 3: multi-stroke run across the index wrap with a zero-length stroke
    b0 = beats; d0 = done_cnt;
    push_run(7'd126, 3, 99);
    do_start(7'd126, 7'd3);
    wait_done("s3", 40);
    repeat (4) @(negedge clk);
    check("s3_beats", 64'(beats - b0), 64'd3);
    check("s3_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("s3_queue", 64'(exp_q.size()), 64'd0);
    check("s3_busy", 64'(busy), 64'd0);

    // 4: empty run
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; first_stroke = 7'd3; stroke_cnt = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("s4_done", 64'(done), 64'd1);
    check("s4_busy", 64'(busy), 64'd0);
    check("s4_valid", 64'(pt_if.pt_valid), 64'd0);
    @(negedge clk);
    check("s4_done_pulse", 64'(done), 64'd0);
    check("s4_busy2", 64'(busy), 64'd0);

    // 5: abort while the second point of a len=4 stroke is presented
    pt_if.pt_ready = 1'b0;
    b0 = beats; d0 = done_cnt;
    push_run(7'd10, 1, 1);
    do_start(7'd10, 7'd1);
    wait_valid("s5a", 10);
    @(posedge clk); #1; pt_if.pt_ready = 1'b1;
    @(posedge clk); #1; pt_if.pt_ready = 1'b0;
    wait_valid("s5b", 10);
    check("s5_second_n", 64'(mem_n), 64'd1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("s5_valid", 64'(pt_if.pt_valid), 64'd0);
    check("s5_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check("s5_no_done", 64'(done_cnt - d0), 64'd0);
    check("s5_beats", 64'(beats - b0), 64'd1);
    pt_if.pt_ready = 1'b1;
    b0 = beats;
    push_run(7'd10, 1, 99);
    do_start(7'd10, 7'd1);
    wait_done("s5c", 30);
    repeat (2) @(negedge clk);
    check("s5_restart_beats", 64'(beats - b0), 64'd4);
    check("s5_queue", 64'(exp_q.size()), 64'd0);

    // 6: asynchronous reset mid-run
    pt_if.pt_ready = 1'b0;
    d0 = done_cnt; b0 = beats;
    push_run(7'd3, 1, 99);
    do_start(7'd3, 7'd1);
    wait_valid("s6", 10);
    #2 rst_n = 1'b0;
    #1;
    check("s6_valid", 64'(pt_if.pt_valid), 64'd0);
    check("s6_busy", 64'(busy), 64'd0);
    check("s6_beat", 64'(cur_beat), 64'd0);
    check("s6_mem_mn", 64'({mem_m, mem_n}), 64'd0);
    exp_q.delete();
    pt_if.pt_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("s6_idle_valid", 64'(pt_if.pt_valid), 64'd0);
    end
    check("s6_no_done", 64'(done_cnt - d0), 64'd0);
    check("s6_no_beats", 64'(beats - b0), 64'd0);
    check("s6_busy_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
